// File: rtl/instr_fetch_issue.sv
// Fetch-and-issue front end: walks the PC through instruction memory, latches
// each word into IR and presents its decoded fields downstream until accepted.
module instr_fetch_issue #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_valid,
  input  logic [15:0]       imem_rdata,
  output logic              issue_valid,
  input  logic              issue_ready,
  output logic [2:0]        opcode,
  output logic [2:0]        rd,
  output logic [2:0]        rs1,
  output logic [2:0]        rs2,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              fetch_err,
  output logic [15:0]       instr_count
);

  localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_HALT
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc_q, pc_nxt;
  logic [15:0]       ir_q, ir_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic              err_q, err_nxt;
  logic [15:0]       count_q, count_nxt;
  logic              req_q, vld_q, busy_q, halted_q;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic is_halt(input logic [15:0] w);
    return (w[3:0] == 4'hF);
  endfunction

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    ir_nxt    = ir_q;
    cnt_nxt   = cnt_q;
    err_nxt   = err_q;
    count_nxt = count_q;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_FETCH;
          cnt_nxt   = '0;
        end
      end
      S_FETCH: begin
        // A word arriving on the timeout cycle takes priority over the error.
        if (imem_valid) begin
          ir_nxt    = imem_rdata;
          pc_nxt    = pc_q + ADDR_W'(1);
          state_nxt = is_halt(imem_rdata) ? S_HALT : S_ISSUE;
        end else if (cnt_q == CNT_LAST) begin
          state_nxt = S_HALT;
          err_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      S_ISSUE: begin
        if (issue_ready) begin
          state_nxt = S_FETCH;
          cnt_nxt   = '0;
          count_nxt = sat_inc16(count_q);
        end
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State register; handshake/status flags registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      count_q  <= '0;
      req_q    <= 1'b0;
      vld_q    <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc_q     <= pc_nxt;
      ir_q     <= ir_nxt;
      cnt_q    <= cnt_nxt;
      err_q    <= err_nxt;
      count_q  <= count_nxt;
      req_q    <= (state_nxt == S_FETCH);
      vld_q    <= (state_nxt == S_ISSUE);
      busy_q   <= (state_nxt == S_FETCH) || (state_nxt == S_ISSUE);
      halted_q <= (state_nxt == S_HALT);
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign issue_valid = vld_q;
  assign opcode      = ir_q[15:13];
  assign rd          = ir_q[12:10];
  assign rs1         = ir_q[9:7];
  assign rs2         = ir_q[6:4];
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign fetch_err   = err_q;
  assign instr_count = count_q;

endmodule

// File: doc/instr_fetch_issue.md
Name: instr_fetch_issue

Overview:
- Fetch-and-issue front end of the mini CPU.
- Holds the program counter and fetches 16-bit instructions from instruction memory over a req/valid handshake.
- Latches each fetched word into an instruction register, decodes its fields and issues it downstream with a valid/ready handshake.
- The issued opcode feeds the control unit directly; register fields feed the register file; halt and fetch-timeout are handled locally.

Parameters:
- ADDR_W, 8, instruction address / PC width.
- RESET_PC, 0, PC value loaded on reset.
- TIMEOUT, 16, consecutive FETCH cycles without imem_valid before fetch error (must be ≥1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin execution; sampled only in IDLE.
- imem_req  output  1  fetch request; high throughout FETCH.
- imem_addr  output  ADDR_W  fetch address; equals pc.
- imem_valid  input  1  instruction word valid; sampled only in FETCH.
- imem_rdata  input  16  instruction word.
- issue_valid  output  1  decoded instruction available; high throughout ISSUE.
- issue_ready  input  1  downstream accepts the instruction.
- opcode  output  3  IR[15:13]; drives control unit opcode.
- rd  output  3  IR[12:10].
- rs1  output  3  IR[9:7].
- rs2  output  3  IR[6:4].
- pc  output  ADDR_W  current program counter.
- busy  output  1  high in FETCH or ISSUE.
- halted  output  1  high in HALT.
- fetch_err  output  1  sticky; set on fetch timeout.
- instr_count  output  16  number of instructions issued; saturates at 16'hFFFF.

Behaviour:
- All state and outputs are registered. Reset values:
  - state=IDLE, pc=RESET_PC, IR=0 (so opcode/rd/rs1/rs2=0).
  - imem_req=0, issue_valid=0, busy=0, halted=0, fetch_err=0, instr_count=0, timeout counter=0.
- Instruction format:
  - [15:13] opcode, [12:10] rd, [9:7] rs1, [6:4] rs2, [3:0] ctl.
  - ctl==4'hF marks a HALT instruction. Other ctl values are reserved and ignored.
- State machine:
  - IDLE:
    - start=1 → FETCH, with the timeout counter cleared.
    - Otherwise remain in IDLE.
  - FETCH:
    - imem_req=1, imem_addr=pc.
    - imem_valid=1:
      - IR←imem_rdata.
      - pc←pc+1, modulo 2^ADDR_W (wraps from all-ones to 0).
      - If ctl==4'hF → HALT. The halt instruction is not issued and instr_count is unchanged.
      - Otherwise → ISSUE.
    - imem_valid=0:
      - If counter==TIMEOUT-1 → HALT, with fetch_err←1 and pc unchanged.
      - Otherwise counter←counter+1.
    - imem_valid=1 in the same cycle the limit is reached: the valid wins and no error is raised.
  - ISSUE:
    - issue_valid=1. opcode/rd/rs1/rs2 stay stable from IR until accepted.
    - issue_ready=1 → FETCH, with counter cleared and instr_count incremented (saturating).
    - issue_ready=0 → hold in ISSUE indefinitely.
  - HALT:
    - halted=1, imem_req=0, issue_valid=0.
    - Exit only via rst; start is ignored.
- start is ignored in every state except IDLE.
- Latency:
  - start sampled at edge n → imem_req high after edge n.
  - Word accepted at edge m → issue_valid high after edge m.
  - Best case is one instruction issued every 2 cycles.
- Reset assertion in any state, including mid-fetch or mid-issue, immediately forces all reset values. The in-flight word is discarded.
- Outputs from FETCH and ISSUE are mutually exclusive: imem_req and issue_valid are never both high.

Test Plan:
- Reset, start=1 one cycle, memory returns valid same cycle as req with words 16'h2480 and 16'h4910, issue_ready=1 → opcode 1 then 2, rd 1/2, rs1 1/2, issue_valid every 2nd cycle, pc 0→1→2, instr_count=2.
- Hold issue_ready=0 for 5 cycles during ISSUE → issue_valid and opcode/rd/rs1/rs2 stable for all 5 cycles; pc not advanced past 1; no imem_req.
- Word 16'h000F fetched at pc=3 → HALT next cycle, halted=1, pc=4, instr_count unchanged, no issue_valid; start pulse afterwards ignored.
- TIMEOUT=16, imem_valid held 0 → after 16 FETCH cycles halted=1, fetch_err=1, pc unchanged. Repeat with valid on cycle 16 → accepted, fetch_err=0.
- ADDR_W=8, RESET_PC=8'hFF, one non-halt fetch → pc wraps to 8'h00, imem_addr=8'h00 on next fetch.
- Assert rst while in ISSUE with issue_ready=0 → same cycle all outputs at reset values, state IDLE, pc=RESET_PC.
